// File: rtl/text_buf_ctrl.sv
// Write-side controller for the character display buffer: round-robin byte intake,
// cursor-control decoding and buffer writes. Define TEXT_CTRL_CLEAR_EN for the screen-clear sequencer.
module text_buf_ctrl #(
    parameter int GRID_COL = 10,
    parameter int GRID_ROW = 5,
    parameter int ADDR_W   = 6
) (
    input  logic              clk_pix,
    input  logic              rst_n,
    input  logic              kb_valid,
    input  logic [7:0]        kb_ascii,
    output logic              kb_ready,
    input  logic              host_valid,
    input  logic [7:0]        host_ascii,
    output logic              host_ready,
    input  logic [3:0]        colorIndexF,
    input  logic [3:0]        colorIndexB,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] cursor_addr
);

    localparam int N = GRID_COL * GRID_ROW;

    // Cursor arithmetic runs one bit wider than the address so nothing wraps early.
    localparam logic [ADDR_W:0]   N_E    = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   COL_E  = (ADDR_W+1)'(GRID_COL);
    localparam logic [ADDR_W:0]   TOP_E  = (ADDR_W+1)'((GRID_ROW - 1) * GRID_COL);
    localparam logic [ADDR_W:0]   ONE_E  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);

`ifdef TEXT_CTRL_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              prefer_host_q, prefer_host_d;

    logic              clr_go;
    logic              grant_host;
    logic              accept;
    logic [7:0]        byte_in;

`ifdef TEXT_CTRL_CLEAR_EN
    // Set by reset so that the first cycle after release starts an automatic clear.
    logic              boot_clr_q, boot_clr_d;
    assign clr_go = clr_req | boot_clr_q;
`else
    logic              unused_clr;
    assign unused_clr = clr_req;
    assign clr_go     = 1'b0;
`endif

    // With both or neither source valid the pointer decides; a lone valid source always wins.
    always_comb begin
        if (kb_valid && host_valid)
            grant_host = prefer_host_q;
        else if (kb_valid || host_valid)
            grant_host = host_valid;
        else
            grant_host = prefer_host_q;
    end

    assign kb_ready   = (state_q == IDLE) && !clr_go && !grant_host;
    assign host_ready = (state_q == IDLE) && !clr_go &&  grant_host;
    assign accept     = (kb_valid && kb_ready) || (host_valid && host_ready);
    assign byte_in    = grant_host ? host_ascii : kb_ascii;

    logic [ADDR_W:0] c_ext, c_inc, c_dec, c_up, c_down, c_row, c_enter;

    always_comb begin
        c_ext   = {1'b0, cursor_q};
        c_inc   = (c_ext + ONE_E == N_E) ? '0 : c_ext + ONE_E;
        c_dec   = (c_ext == '0) ? N_E - ONE_E : c_ext - ONE_E;
        c_up    = (c_ext >= COL_E) ? c_ext - COL_E : c_ext + TOP_E;
        c_down  = (c_ext < TOP_E) ? c_ext + COL_E : c_ext - TOP_E;
        c_row   = c_ext - (c_ext % COL_E) + COL_E;
        c_enter = (c_row >= N_E) ? '0 : c_row;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        prefer_host_d = prefer_host_q;
`ifdef TEXT_CTRL_CLEAR_EN
        boot_clr_d    = boot_clr_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef TEXT_CTRL_CLEAR_EN
                if (clr_go) begin
                    state_d    = CLEAR;
                    boot_clr_d = 1'b0;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = {colorIndexB, colorIndexF, 8'h00};
                end else
`endif
                if (accept) begin
                    state_d       = WRITE;
                    prefer_host_d = !grant_host;
                    if (byte_in inside {[8'h20:8'h7E]}) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cursor_q;
                        wr_data_d = {colorIndexB, colorIndexF, byte_in};
                        cursor_d  = c_inc[ADDR_W-1:0];
                    end else begin
                        case (byte_in)
                            8'h7F: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = c_dec[ADDR_W-1:0];
                                wr_data_d = {colorIndexB, colorIndexF, 8'h00};
                                cursor_d  = c_dec[ADDR_W-1:0];
                            end
                            8'h11:   cursor_d = c_dec[ADDR_W-1:0];
                            8'h14:   cursor_d = c_inc[ADDR_W-1:0];
                            8'h12:   cursor_d = c_up[ADDR_W-1:0];
                            8'h13:   cursor_d = c_down[ADDR_W-1:0];
                            8'h0D:   cursor_d = c_enter[ADDR_W-1:0];
                            default: cursor_d = cursor_q;
                        endcase
                    end
                end
            end

            WRITE: state_d = IDLE;

`ifdef TEXT_CTRL_CLEAR_EN
            CLEAR: begin
                if (wr_addr_q == LAST_A) begin
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
`endif

            default: state_d = IDLE;
        endcase

`ifdef TEXT_CTRL_CLEAR_EN
        // Cursor homes in the same cycle as the final clear write.
        if (state_d == CLEAR && wr_addr_d == LAST_A)
            cursor_d = '0;
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cursor_q      <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            prefer_host_q <= 1'b0;
`ifdef TEXT_CTRL_CLEAR_EN
            boot_clr_q    <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            prefer_host_q <= prefer_host_d;
`ifdef TEXT_CTRL_CLEAR_EN
            boot_clr_q    <= boot_clr_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign cursor_addr = cursor_q;

endmodule
